packet_sched: RTL and testbench
===============================

# packet_sched

Packet scheduler between the RAM-bus tracing state machine and the USB FIFO interface. It buffers 32-bit trace words in a small FIFO, because the trace source cannot be stalled. It arbitrates the USB packet path between trace words and a handshaked status/readback requester, and it accounts for trace words dropped on overflow. It sits in the top level between the packet assembly logic and `usb_comm`, and presents one word per cycle at most under downstream flow control.

## Interface
- DEPTH_LOG2, 4: trace FIFO depth is 2^DEPTH_LOG2 words.
- STATUS_MAX_WAIT, 64: cycles a pending status request may wait before it preempts trace traffic.
- OVF_MARKER, 16'hFFFE: upper 16 bits of the overflow marker word.
- mclk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- trace_data  in  32  assembled trace word.
- trace_strobe  in  1  one-cycle write of trace_data; has no backpressure.
- status_req  in  1  status word pending; held high until acked.
- status_data  in  32  status word; stable while status_req is high.
- status_ack  out  1  one-cycle pulse; status word taken.
- out_ready  in  1  downstream can accept a word this cycle.
- out_data  out  32  registered output word.
- out_strobe  out  1  one-cycle pulse; out_data is valid.
- fifo_level  out  DEPTH_LOG2+1  current trace FIFO occupancy.
- ovf_total  out  16  saturating count of dropped trace words, cleared only by reset.

## Operation
Reset values:
- All outputs are 0.
- The FIFO is empty, with read and write pointers at 0.
- The drop and wait counters are 0.

Trace FIFO:
- A trace_strobe with the FIFO not full writes trace_data at the write pointer.
- A trace_strobe with the FIFO full drops the word. ovf_total increments, saturating at 16'hFFFF, and drop_count increments, also saturating.
- The pointers are DEPTH_LOG2+1 bits wide and wrap naturally. Full means the MSBs differ and the low bits are equal.
- A write and a pop in the same cycle on a full FIFO are both performed, with no drop.

Grant, evaluated every cycle with out_ready=1:
- Priority 1, status: status_req=1, status_ack not high this cycle, and either the FIFO is empty or wait_cnt >= STATUS_MAX_WAIT.
- Priority 2, trace: the FIFO is not empty.
- Otherwise nothing is granted.

Wait counter:
- wait_cnt increments, saturating, each cycle status_req=1 and status is not granted.
- wait_cnt clears on a status grant or when status_req=0.

Granting a source:
- A grant loads out_data at the clock edge. out_strobe=1 in the following cycle.
- status_ack pulses in the same cycle as the out_strobe that carries the status word.
- The requester drops status_req after seeing status_ack. status_req is ignored while status_ack=1, which prevents a double grant.

Flow control:
- With out_ready=0, no grant is made and out_strobe=0 next cycle.
- out_data holds its last value.
- FIFO writes continue normally.

## Timing
- Trace latency: a strobe in cycle N into an empty FIFO, with out_ready=1, gives out_strobe in cycle N+2.
- Status latency: status_req rising in cycle N with the FIFO empty gives out_strobe and status_ack in cycle N+1.
- Throughput: one word per cycle while out_ready=1.
- fifo_level reflects writes and pops one cycle after they occur (registered).
- A reset mid-operation discards FIFO contents and any pending marker. Outputs return to 0 asynchronously.

## Configuration
- PACKET_SCHED_OVF_MARKER_EN defined: the overflow marker feature is compiled in.
  - When drop_count != 0, the first cycle the FIFO has a free slot writes the marker word {OVF_MARKER, drop_count} into the FIFO, in place of any trace write.
  - A trace_strobe in that same cycle is dropped. It is included in the marker count (drop_count+1, saturating) and in ovf_total.
  - drop_count clears when the marker is written.
- PACKET_SCHED_OVF_MARKER_EN undefined: no marker is written and drop_count logic is absent. Drops are visible only through ovf_total.

## Test plan
- Single trace word 32'h12345678 at cycle 0, FIFO empty, out_ready=1 -> out_strobe=1 with out_data=32'h12345678 at cycle 2; fifo_level returns to 0.
- 20 back-to-back strobes with out_ready=0 and depth 16 -> fifo_level=16, ovf_total=4.
  - Release out_ready: 16 words out in order.
  - With the macro defined, a marker 32'hFFFE0004 follows them.
- Status request while 3 trace words are queued, STATUS_MAX_WAIT=2 -> trace word, trace word, then status once wait_cnt reaches 2.
  - status_ack is coincident with its out_strobe, followed by the remaining trace word.
  - Exactly one status word is emitted.
- FIFO full, with a simultaneous strobe and pop every cycle for 10 cycles -> no drops, ovf_total unchanged, fifo_level stays 16.
- Drive 70000 drops -> ovf_total saturates at 16'hFFFF. Assert reset mid-burst -> all outputs 0 immediately and the FIFO empty; no marker after reset.

Source files
------------

// File: rtl/packet_sched.sv
// packet_sched: trace FIFO plus arbiter feeding the USB packet path.
// Trace words are buffered because the trace source cannot be stalled.
// A handshaked status requester may preempt trace traffic once it has waited long enough.
// Words dropped on overflow are counted in ovf_total.
// Optional feature: define PACKET_SCHED_OVF_MARKER_EN to compile in the overflow marker.
// The marker is {OVF_MARKER, drop_count}, written into the FIFO once a slot frees up.
module packet_sched #(
  parameter int unsigned DEPTH_LOG2      = 4,
  parameter int unsigned STATUS_MAX_WAIT = 64,
  parameter logic [15:0] OVF_MARKER      = 16'hFFFE
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [31:0]           trace_data,
  input  logic                  trace_strobe,
  input  logic                  status_req,
  input  logic [31:0]           status_data,
  output logic                  status_ack,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_strobe,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           ovf_total
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  // Wide enough that wait_cnt can reach STATUS_MAX_WAIT before saturating.
  localparam int unsigned WaitW = $clog2(STATUS_MAX_WAIT + 1) + 1;

  logic [31:0]         mem [Depth];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [WaitW-1:0]    wait_cnt;

  logic        fifo_empty;
  logic        fifo_full;
  logic        status_win;
  logic        grant_status;
  logic        grant_trace;
  logic        can_write;
  logic        fifo_we;
  logic [31:0] fifo_wdata;
  logic        drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;

  // Arbitration: status wins when the FIFO is idle or the request has starved long enough.
  // status_req is ignored during status_ack so a held request cannot be granted twice.
  always_comb begin
    status_win   = status_req && !status_ack &&
                   (fifo_empty || (wait_cnt >= WaitW'(STATUS_MAX_WAIT)));
    grant_status = out_ready && status_win;
    grant_trace  = out_ready && !status_win && !fifo_empty;
    // A pop in the same cycle frees the slot for a write, even when the FIFO is full.
    can_write    = !fifo_full || grant_trace;
  end

`ifdef PACKET_SCHED_OVF_MARKER_EN
  logic [15:0] drop_count;
  logic        marker_write;
  logic [15:0] marker_cnt;

  // The marker takes the free slot, and a coincident trace word is dropped into its count.
  always_comb begin
    marker_write = (drop_count != 16'd0) && can_write;
    marker_cnt   = drop_count;
    if (trace_strobe && (drop_count != 16'hFFFF)) begin
      marker_cnt = drop_count + 16'd1;
    end
    fifo_we    = marker_write || (trace_strobe && can_write);
    fifo_wdata = marker_write ? {OVF_MARKER, marker_cnt} : trace_data;
    drop       = trace_strobe && (!can_write || marker_write);
  end

  // Count drops since the last marker. The count clears when the marker is written.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      drop_count <= 16'd0;
    end else if (marker_write) begin
      drop_count <= 16'd0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  // Without the marker, a trace word is written whenever a slot is free.
  always_comb begin
    fifo_we    = trace_strobe && can_write;
    fifo_wdata = trace_data;
    drop       = trace_strobe && !can_write;
  end
`endif

  // FIFO storage. It needs no reset because the pointers define what is valid.
  always_ff @(posedge mclk) begin
    if (fifo_we) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= fifo_wdata;
    end
  end

  // FIFO pointers. They wrap naturally, and the extra MSB separates full from empty.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_trace) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Starvation counter for a pending status request.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!status_req || grant_status) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + WaitW'(1);
    end
  end

  // Saturating lifetime drop counter.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      ovf_total <= 16'd0;
    end else if (drop && (ovf_total != 16'hFFFF)) begin
      ovf_total <= ovf_total + 16'd1;
    end
  end

  // Output register. out_data holds its value when nothing is granted.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      out_data   <= 32'd0;
      out_strobe <= 1'b0;
      status_ack <= 1'b0;
    end else begin
      out_strobe <= grant_status || grant_trace;
      status_ack <= grant_status;
      if (grant_status) begin
        out_data <= status_data;
      end else if (grant_trace) begin
        out_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_packet_sched.sv
// Directed bench for packet_sched. It uses a table of per-cycle vectors plus hand-written sequences.
// Inputs are driven at the falling edge. Outputs for the same cycle are checked just before the drive.
module tb_packet_sched;

  localparam int unsigned DepthLog2 = 4;

  logic                 mclk;
  logic                 reset;
  logic [31:0]          trace_data;
  logic                 trace_strobe;
  logic                 status_req;
  logic [31:0]          status_data;
  logic                 status_ack;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic                 out_strobe;
  logic [DepthLog2:0]   fifo_level;
  logic [15:0]          ovf_total;

  int checks;
  int errors;

  packet_sched #(
    .DEPTH_LOG2     (DepthLog2),
    .STATUS_MAX_WAIT(2),
    .OVF_MARKER     (16'hFFFE)
  ) dut (
    .mclk        (mclk),
    .reset       (reset),
    .trace_data  (trace_data),
    .trace_strobe(trace_strobe),
    .status_req  (status_req),
    .status_data (status_data),
    .status_ack  (status_ack),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_strobe  (out_strobe),
    .fifo_level  (fifo_level),
    .ovf_total   (ovf_total)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic        strobe;
    logic [31:0] tdata;
    logic        sreq;
    logic [31:0] sdata;
    logic        ready;
    logic        e_str;
    logic        e_ack;
    logic [31:0] e_data;
    int unsigned e_lvl;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic s, input logic [31:0] td, input logic sr,
                              input logic [31:0] sd, input logic rdy, input logic es,
                              input logic ea, input logic [31:0] ed, input int unsigned el);
    vec_t v;
    v.strobe = s;  v.tdata = td; v.sreq = sr; v.sdata = sd; v.ready = rdy;
    v.e_str  = es; v.e_ack = ea; v.e_data = ed; v.e_lvl = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    trace_strobe = 1'b0;
    trace_data   = 32'd0;
    status_req   = 1'b0;
    status_data  = 32'd0;
    out_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    reset = 1'b0;
  endtask

  localparam logic [31:0] T   = 32'h1234_5678;
  localparam logic [31:0] SW  = 32'hC0DE_0001;
  localparam logic [31:0] SW2 = 32'hC0DE_0002;
  localparam logic [31:0] D1  = 32'h1111_1111;
  localparam logic [31:0] D2  = 32'h2222_2222;
  localparam logic [31:0] D3  = 32'h3333_3333;

  logic [31:0] exp_q[$];
  int          got;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();

    // Single trace word, immediate status grant with no double grant,
    // then status preempting queued trace words after two waiting cycles.
    vecs[0]  = mk(1, T,  0, 0,   1, 0, 0, 0,   0);
    vecs[1]  = mk(0, 0,  0, 0,   1, 0, 0, 0,   1);
    vecs[2]  = mk(0, 0,  0, 0,   1, 1, 0, T,   0);
    vecs[3]  = mk(0, 0,  0, 0,   1, 0, 0, T,   0);
    vecs[4]  = mk(0, 0,  1, SW,  1, 0, 0, T,   0);
    vecs[5]  = mk(0, 0,  1, SW,  1, 1, 1, SW,  0);
    vecs[6]  = mk(0, 0,  0, 0,   1, 0, 0, SW,  0);
    vecs[7]  = mk(0, 0,  0, 0,   1, 0, 0, SW,  0);
    vecs[8]  = mk(1, D1, 0, 0,   0, 0, 0, SW,  0);
    vecs[9]  = mk(1, D2, 0, 0,   0, 0, 0, SW,  1);
    vecs[10] = mk(1, D3, 0, 0,   0, 0, 0, SW,  2);
    vecs[11] = mk(0, 0,  1, SW2, 1, 0, 0, SW,  3);
    vecs[12] = mk(0, 0,  1, SW2, 1, 1, 0, D1,  2);
    vecs[13] = mk(0, 0,  1, SW2, 1, 1, 0, D2,  1);
    vecs[14] = mk(0, 0,  1, SW2, 1, 1, 1, SW2, 1);
    vecs[15] = mk(0, 0,  0, 0,   1, 1, 0, D3,  0);
    vecs[16] = mk(0, 0,  0, 0,   1, 0, 0, D3,  0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      check($sformatf("v%0d out_strobe", i), 32'(out_strobe), 32'(vecs[i].e_str));
      check($sformatf("v%0d status_ack", i), 32'(status_ack), 32'(vecs[i].e_ack));
      check($sformatf("v%0d out_data", i), out_data, vecs[i].e_data);
      check($sformatf("v%0d fifo_level", i), 32'(fifo_level), vecs[i].e_lvl);
      check($sformatf("v%0d ovf_total", i), 32'(ovf_total), 32'd0);
      trace_strobe = vecs[i].strobe;
      trace_data   = vecs[i].tdata;
      status_req   = vecs[i].sreq;
      status_data  = vecs[i].sdata;
      out_ready    = vecs[i].ready;
      @(negedge mclk);
    end

    // Overflow: 20 strobes into a depth-16 FIFO with the output stalled.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      trace_strobe = 1'b1;
      trace_data   = 32'hA000_0000 + 32'(i);
      @(negedge mclk);
    end
    trace_strobe = 1'b0;
    check("ovf fifo_level", 32'(fifo_level), 32'd16);
    check("ovf ovf_total", 32'(ovf_total), 32'd4);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
`ifdef PACKET_SCHED_OVF_MARKER_EN
    exp_q.push_back(32'hFFFE_0004);
`endif
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge mclk);
      if (out_strobe) begin
        if (got < exp_q.size()) check($sformatf("drain word %0d", got), out_data, exp_q[got]);
        got++;
      end
    end
    check("drain word count", 32'(got), 32'(exp_q.size()));
    check("drain fifo_level", 32'(fifo_level), 32'd0);
    check("drain ovf_total", 32'(ovf_total), 32'd4);

    // Full FIFO with simultaneous write and pop every cycle: no drops.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      trace_strobe = 1'b1;
      trace_data   = 32'hB000_0000 + 32'(i);
      @(negedge mclk);
    end
    check("full fifo_level", 32'(fifo_level), 32'd16);
    for (int j = 0; j < 10; j++) begin
      out_ready    = 1'b1;
      trace_strobe = 1'b1;
      trace_data   = 32'hC000_0000 + 32'(j);
      @(negedge mclk);
      check($sformatf("full pop %0d out_strobe", j), 32'(out_strobe), 32'd1);
      check($sformatf("full pop %0d out_data", j), out_data, 32'hB000_0000 + 32'(j));
      check($sformatf("full pop %0d fifo_level", j), 32'(fifo_level), 32'd16);
      check($sformatf("full pop %0d ovf_total", j), 32'(ovf_total), 32'd0);
    end
    idle_inputs();

    // Saturation: 16 fills plus 70000 drops, then a reset mid-burst.
    do_reset();
    trace_strobe = 1'b1;
    for (int i = 0; i < 70016; i++) begin
      trace_data = 32'h5000_0000 + 32'(i);
      @(negedge mclk);
    end
    check("sat ovf_total", 32'(ovf_total), 32'hFFFF);
    check("sat fifo_level", 32'(fifo_level), 32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge mclk);
    check("pre-reset out_strobe", 32'(out_strobe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst out_data", out_data, 32'd0);
    check("async rst out_strobe", 32'(out_strobe), 32'd0);
    check("async rst status_ack", 32'(status_ack), 32'd0);
    check("async rst fifo_level", 32'(fifo_level), 32'd0);
    check("async rst ovf_total", 32'(ovf_total), 32'd0);
    @(negedge mclk);
    reset        = 1'b0;
    trace_strobe = 1'b0;
    out_ready    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      check($sformatf("post-reset idle %0d", i), 32'(out_strobe), 32'd0);
    end
    check("post-reset fifo_level", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
